// File: rtl/jk_bank_controller.sv
// Command sequencer for a bank of JK flip-flops: accepts one command at a time
// and decodes per-bit J/K drive from the fed-back bank state q.
package jk_bank_controller_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'b000,
        OP_LOAD       = 3'b001,
        OP_COUNT_UP   = 3'b010,
        OP_COUNT_DOWN = 3'b011,
        OP_SHIFT_LEFT = 3'b100,
        OP_TOGGLE     = 3'b101,
        OP_CLEAR_BANK = 3'b110,
        OP_RESERVED   = 3'b111
    } op_t;

endpackage

module jk_bank_controller
    import jk_bank_controller_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             ff_clear,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state, state_n;
    op_t              op_q, op_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [CNT_W-1:0] steps_q, steps_n;
    logic [CNT_W-1:0] accept_steps;
    logic [WIDTH-1:0] up_t, dn_t;

    // Step count implied by the incoming opcode; count field only matters for multi-step ops.
    always_comb begin
        case (op_t'(cmd_op))
            OP_LOAD, OP_CLEAR_BANK:                              accept_steps = CNT_W'(1);
            OP_COUNT_UP, OP_COUNT_DOWN, OP_SHIFT_LEFT, OP_TOGGLE: accept_steps = cmd_count;
            default:                                             accept_steps = '0;
        endcase
    end

    // State and command registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            data_q    <= '0;
            steps_q   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            data_q    <= data_n;
            steps_q   <= steps_n;
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        data_n  = data_q;
        steps_n = steps_q;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_n    = op_t'(cmd_op);
                    data_n  = cmd_data;
                    steps_n = accept_steps;
                    state_n = (accept_steps == '0) ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                steps_n = steps_q - CNT_W'(1);
                if (steps_q == CNT_W'(1)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign steps_left = steps_q;

    // Toggle enables for counting: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic up_run;
        logic dn_run;
        up_run = 1'b1;
        dn_run = 1'b1;
        up_t   = '0;
        dn_t   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            up_t[i] = up_run;
            dn_t[i] = dn_run;
            up_run  = up_run & q[i];
            dn_run  = dn_run & ~q[i];
        end
    end

    // Bank drive. clear also gates it so an abort never lands one more step.
    always_comb begin
        j        = '0;
        k        = '0;
        ff_clear = 1'b0;
        if ((state == S_EXEC) && !clear) begin
            case (op_q)
                OP_LOAD: begin
                    j = data_q;
                    k = ~data_q;
                end
                OP_COUNT_UP: begin
                    j = up_t;
                    k = up_t;
                end
                OP_COUNT_DOWN: begin
                    j = dn_t;
                    k = dn_t;
                end
                OP_SHIFT_LEFT: begin
                    j = {q[WIDTH-2:0], data_q[0]};
                    k = ~{q[WIDTH-2:0], data_q[0]};
                end
                OP_TOGGLE: begin
                    j = data_q;
                    k = data_q;
                end
                OP_CLEAR_BANK: ff_clear = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
